// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares one byte-laned data RAM port between two masters:
//   master 0 - core load/store unit
//   master 1 - debug / loader port
// Round-robin arbitration picks one request in IDLE or RESP. Each accepted
// request becomes exactly one RAM cycle (ACCESS), followed by a one-cycle
// response pulse (RESP) routed only to the master that owns the access.
// Misaligned or invalid-size requests still step through ACCESS, but they
// never drive the RAM, and they answer with err = 1 and rdata = 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mN_req_i          request from master N, held with attributes until gnt
//   mN_we_i           1 = store, 0 = load
//   mN_addr_i         byte address
//   mN_size_i         00 byte, 01 half, 10 word, 11 invalid
//   mN_wdata_i        right-aligned store data
//   mN_gnt_o          request accepted this cycle (combinational)
//   mN_rvalid_o       one-cycle response pulse
//   mN_rdata_o        right-aligned, zero-extended load data (0 otherwise)
//   mN_err_o          misaligned / invalid access flag, valid with rvalid
//   ram_addr_o        word-aligned RAM address
//   ram_re_o          RAM read enable
//   ram_we_o          RAM write enable
//   ram_be_o          byte-lane write enables
//   ram_wdata_o       lane-replicated store data
//   ram_rdata_i       combinational RAM read data
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [1:0]        m0_size_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [1:0]        m1_size_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,

  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_re_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_be_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // access sizes
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [DATA_W-1:0] MASK_BYTE = DATA_W'(32'h0000_00FF);
  localparam logic [DATA_W-1:0] MASK_HALF = DATA_W'(32'h0000_FFFF);

  // state and latched request
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic              last_grant_reg;   // id of the most recently granted master
  logic              owner_reg;        // master that owns the in-flight access
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              err_reg;
  logic [DATA_W-1:0] rdata_reg;

  // arbitration
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              can_grant;

  // selected request attributes (from the winning master)
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  // RAM side
  logic              access_ok;
  logic [3:0]        be_calc;
  logic [DATA_W-1:0] wdata_calc;
  logic [DATA_W-1:0] byte_shifted;
  logic [DATA_W-1:0] half_shifted;
  logic [DATA_W-1:0] load_data;

  // -------------------------------------------------------------------------
  // Alignment / size check, evaluated on the request being granted.
  // -------------------------------------------------------------------------
  function automatic logic access_err(input logic [1:0] size,
                                      input logic [1:0] lo);
    case (size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = lo[0];
      SZ_WORD: access_err = (lo != 2'b00);
      default: access_err = 1'b1;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Arbitration. Grants only in IDLE or RESP. On a tie, the master that was
  // not granted last wins; in RESP last_grant equals the master being
  // responded to, so the other master gets the next slot.
  // -------------------------------------------------------------------------
  assign req       = {m1_req_i, m0_req_i};
  assign can_grant = (state_reg == ST_IDLE) || (state_reg == ST_RESP);

  always_comb begin
    gnt = 2'b00;
    if (can_grant) begin
      if (req == 2'b11) begin
        gnt = last_grant_reg ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  assign sel_we    = gnt[1] ? m1_we_i    : m0_we_i;
  assign sel_addr  = gnt[1] ? m1_addr_i  : m0_addr_i;
  assign sel_size  = gnt[1] ? m1_size_i  : m0_size_i;
  assign sel_wdata = gnt[1] ? m1_wdata_i : m0_wdata_i;
  assign sel_err   = access_err(sel_size, sel_addr[1:0]);

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE:   state_next = (|gnt) ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = (|gnt) ? ST_ACCESS : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Store lane formatting from the latched request.
  // -------------------------------------------------------------------------
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata_reg;
    case (size_reg)
      SZ_BYTE: begin
        be_calc    = 4'b0001 << addr_reg[1:0];
        wdata_calc = {4{wdata_reg[7:0]}};
      end
      SZ_HALF: begin
        be_calc    = 4'b0011 << {addr_reg[1], 1'b0};
        wdata_calc = {2{wdata_reg[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_reg;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Load alignment: shift the addressed lane(s) down to bit 0, then mask.
  // -------------------------------------------------------------------------
  assign byte_shifted = ram_rdata_i >> {addr_reg[1:0], 3'b000};
  assign half_shifted = ram_rdata_i >> {addr_reg[1], 4'b0000};

  always_comb begin
    load_data = '0;
    if (access_ok && !we_reg) begin
      case (size_reg)
        SZ_BYTE: load_data = byte_shifted & MASK_BYTE;
        SZ_HALF: load_data = half_shifted & MASK_HALF;
        default: load_data = ram_rdata_i;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // RAM port: driven only during an ACCESS cycle of a legal request; every
  // other cycle (including an erroring ACCESS) leaves all RAM outputs at 0.
  // Loads leave the lane enables and write data at 0.
  // -------------------------------------------------------------------------
  assign access_ok   = (state_reg == ST_ACCESS) && !err_reg;
  assign ram_re_o    = access_ok && !we_reg;
  assign ram_we_o    = access_ok && we_reg;
  assign ram_addr_o  = access_ok ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign ram_be_o    = ram_we_o ? be_calc : 4'b0000;
  assign ram_wdata_o = ram_we_o ? wdata_calc : '0;

  // -------------------------------------------------------------------------
  // Response routing: only the owner sees rvalid; rdata/err are gated so the
  // other master always reads 0.
  // -------------------------------------------------------------------------
  assign m0_rvalid_o = (state_reg == ST_RESP) && !owner_reg;
  assign m1_rvalid_o = (state_reg == ST_RESP) &&  owner_reg;
  assign m0_err_o    = m0_rvalid_o && err_reg;
  assign m1_err_o    = m1_rvalid_o && err_reg;
  assign m0_rdata_o  = m0_rvalid_o ? rdata_reg : '0;
  assign m1_rdata_o  = m1_rvalid_o ? rdata_reg : '0;

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;   // makes master 0 win the first tie
      owner_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      size_reg       <= 2'b00;
      wdata_reg      <= '0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      state_reg <= state_next;

      if (|gnt) begin
        last_grant_reg <= gnt[1];
        owner_reg      <= gnt[1];
        we_reg         <= sel_we;
        addr_reg       <= sel_addr;
        size_reg       <= sel_size;
        wdata_reg      <= sel_wdata;
        err_reg        <= sel_err;
      end

      // load_data is already 0 for stores and erroring accesses
      if (state_reg == ST_ACCESS) begin
        rdata_reg <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter: a table of single-master transactions with
// hand-computed RAM-side and response-side values, plus hand-written
// sequences for continuous contention and reset during an access.
// A small behavioural RAM (256 words) sits on the RAM port.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        m0_req_i, m0_we_i;
  logic [31:0] m0_addr_i;
  logic [1:0]  m0_size_i;
  logic [31:0] m0_wdata_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
  logic [31:0] m0_rdata_o;

  logic        m1_req_i, m1_we_i;
  logic [31:0] m1_addr_i;
  logic [1:0]  m1_size_i;
  logic [31:0] m1_wdata_i;
  logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m1_rdata_o;

  logic [31:0] ram_addr_o;
  logic        ram_re_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req_i    (m0_req_i),
    .m0_we_i     (m0_we_i),
    .m0_addr_i   (m0_addr_i),
    .m0_size_i   (m0_size_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m0_err_o    (m0_err_o),
    .m1_req_i    (m1_req_i),
    .m1_we_i     (m1_we_i),
    .m1_addr_i   (m1_addr_i),
    .m1_size_i   (m1_size_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o),
    .m1_err_o    (m1_err_o),
    .ram_addr_o  (ram_addr_o),
    .ram_re_o    (ram_re_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  // behavioural RAM: combinational read, byte-lane write on the clock edge
  logic [31:0] mem [0:255];
  assign ram_rdata_i = mem[ram_addr_o[9:2]];

  always @(posedge clk) begin
    if (ram_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        pre_en;
    logic [31:0] pre_val;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mst, input logic req, input logic we,
                       input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata);
    if (mst) begin
      m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_size_i = size; m1_wdata_i = wdata;
    end else begin
      m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_size_i = size; m0_wdata_i = wdata;
    end
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
  endtask

  // one transaction: grant (T), RAM cycle (T+1), response (T+2)
  task automatic run_vec(input int idx, input vec_t v);
    logic [1:0]  gnts;
    logic [1:0]  rvs;
    logic [31:0] rdat;
    logic        errs;
    @(negedge clk);
    if (v.pre_en) mem[v.addr[9:2]] <= v.pre_val;
    drive(v.mst, 1'b1, v.we, v.addr, v.size, v.wdata);
    #1;
    gnts = {m1_gnt_o, m0_gnt_o};
    chk("gnt_owner", {31'b0, gnts[v.mst]}, 32'd1);
    chk("gnt_other", {31'b0, gnts[!v.mst]}, 32'd0);

    @(negedge clk);
    drive(v.mst, 1'b0, v.we, v.addr, v.size, v.wdata);
    #1;
    chk("ram_re", {31'b0, ram_re_o}, {31'b0, !v.we && !v.exp_err});
    chk("ram_we", {31'b0, ram_we_o}, {31'b0, v.we && !v.exp_err});
    if (!v.exp_err) chk("ram_addr", ram_addr_o, {v.addr[31:2], 2'b00});
    if (v.we) begin
      chk("ram_be", {28'b0, ram_be_o}, {28'b0, v.exp_be});
      chk("ram_wdata", ram_wdata_o, v.exp_wdata);
    end

    @(negedge clk);
    #1;
    rvs  = {m1_rvalid_o, m0_rvalid_o};
    rdat = v.mst ? m1_rdata_o : m0_rdata_o;
    errs = v.mst ? m1_err_o : m0_err_o;
    chk("rvalid_owner", {31'b0, rvs[v.mst]}, 32'd1);
    chk("rvalid_other", {31'b0, rvs[!v.mst]}, 32'd0);
    chk("rdata", rdat, v.exp_rdata);
    chk("err", {31'b0, errs}, {31'b0, v.exp_err});
    $display("txn %0d m%0d we=%0d addr=%h size=%0d rdata=%h err=%0d",
             idx, v.mst, v.we, v.addr, v.size, rdat, errs);
  endtask

  task automatic chk_all_quiet(input string name);
    chk(name, {20'b0, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o,
               ram_re_o, ram_we_o, ram_be_o}, 32'd0);
    chk({name, "_addr"}, ram_addr_o, 32'd0);
    chk({name, "_wdata"}, ram_wdata_o, 32'd0);
    chk({name, "_rdata"}, m0_rdata_o | m1_rdata_o, 32'd0);
  endtask

  logic [3:0] exp_codes [9];

  initial begin
    // mst we  addr        size   wdata         pre  pre_val        err  be       wdata_exp      rdata_exp
    vecs[0]  = '{1'b0, 1'b0, 32'h10, 2'b10, 32'h0,        1'b1, 32'hA1B2C3D4, 1'b0, 4'b0000, 32'h0,        32'hA1B2C3D4};
    vecs[1]  = '{1'b1, 1'b1, 32'h23, 2'b00, 32'h5A,       1'b0, 32'h0,        1'b0, 4'b1000, 32'h5A5A5A5A, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h22, 2'b01, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h00005A00};
    vecs[3]  = '{1'b0, 1'b1, 32'h06, 2'b10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h00, 2'b11, 32'h0,        1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'h02, 2'b01, 32'h0000BEEF, 1'b1, 32'h11223344, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h00, 2'b10, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hBEEF3344};
    vecs[7]  = '{1'b0, 1'b0, 32'h11, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h000000C3};
    vecs[8]  = '{1'b1, 1'b1, 32'h01, 2'b01, 32'h1234,     1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'h12, 2'b01, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0000A1B2};
    vecs[10] = '{1'b1, 1'b1, 32'h30, 2'b10, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h33, 2'b00, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h000000CA};

    // contention codes {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, one per cycle
    exp_codes = '{4'b1000, 4'b0000, 4'b0110, 4'b0000, 4'b1001,
                  4'b0000, 4'b0110, 4'b0000, 4'b1001};

    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    rst = 1'b1;
    idle_inputs();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk_all_quiet("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // table-driven single-master transactions
    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // back-to-back contention: both masters request continuously
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 2'b10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 2'b10, 32'h0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("contend_c%0d", k),
          {28'b0, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o},
          {28'b0, exp_codes[k]});
      if (exp_codes[k][1]) chk("contend_m0_rdata", m0_rdata_o, 32'hA1B2C3D4);
      if (exp_codes[k][0]) chk("contend_m1_rdata", m1_rdata_o, 32'h5A000000);
      $display("contend cycle %0d gnt=%b%b rvalid=%b%b", k,
               m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o);
    end
    idle_inputs();
    @(negedge clk);
    #1;
    chk("contend_drained", {30'b0, m0_rvalid_o, m1_rvalid_o}, 32'd0);

    // reset asserted during the ACCESS cycle of an m0 load
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 2'b10, 32'h0);
    #1;
    chk("rst_seq_gnt", {31'b0, m0_gnt_o}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h10, 2'b10, 32'h0);
    #1;
    chk("rst_seq_access_re", {31'b0, ram_re_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk_all_quiet("rst_mid_access");
    @(negedge clk);
    #1;
    chk("rst_no_rvalid", {30'b0, m0_rvalid_o, m1_rvalid_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_no_rvalid", {30'b0, m0_rvalid_o, m1_rvalid_o}, 32'd0);
    $display("reset during access: discarded");

    // last grant before reset was m0; reset must restore m0 priority
    drive(1'b0, 1'b1, 1'b0, 32'h10, 2'b10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 2'b10, 32'h0);
    #1;
    chk("post_rst_tie", {30'b0, m1_gnt_o, m0_gnt_o}, 32'd1);
    $display("post-reset tie gnt=%b%b", m0_gnt_o, m1_gnt_o);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_rst_tie_gnt_hold", {30'b0, m0_gnt_o, m1_gnt_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_tie_rvalid", {30'b0, m0_rvalid_o, m1_rvalid_o}, 32'd2);
    chk("post_rst_tie_rdata", m0_rdata_o, 32'hA1B2C3D4);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
